// File: rtl/regfile_wb_sched_pkg.sv
// Shared sizes, the hard-wired zero register and the two-way grant encoding
// for the write-back scheduler.
package regfile_wb_sched_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;
endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, pointer remembers the
// last winner and moves only when a grant is actually consumed.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);
  import regfile_wb_sched_pkg::*;

  grant_e last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    // On a tie the side that did not win most recently takes the grant.
    if (req_i == 2'b11) begin
      gnt_o = (last_q == GRANT_B) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1] ? GRANT_B : GRANT_A;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= GRANT_B;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Issue interlock scoreboard plus arbitrated write-back into a registered
// register-file write port (one-cycle latency), with a sticky stray-write flag.
module regfile_wb_sched #(
  parameter int XLEN = regfile_wb_sched_pkg::XLEN,
  parameter int NREG = regfile_wb_sched_pkg::NREG
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  output logic            iss_stall,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            RegWEn,
  output logic [4:0]      addr_rd,
  output logic [XLEN-1:0] data_rd,
  output logic            idle,
  output logic            wb_err
);
  import regfile_wb_sched_pkg::*;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  err_q, err_d;

  logic [1:0]            gnt;
  logic                  xfer_a, xfer_b, xfer, iss_fire;
  logic [REG_ADDR_W-1:0] xfer_rd;
  logic [XLEN-1:0]       xfer_data;

  assign iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
  assign iss_fire  = iss_valid & ~iss_stall;

  rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_i     ({b_valid, a_valid}),
    .advance_i (xfer),
    .gnt_o     (gnt)
  );

  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign xfer_a    = a_valid & a_ready;
  assign xfer_b    = b_valid & b_ready;
  assign xfer      = xfer_a | xfer_b;
  assign xfer_rd   = xfer_b ? b_rd : a_rd;
  assign xfer_data = xfer_b ? b_data : a_data;

  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[addr_q] = 1'b0;
    end
    // Applied after the commit clear so a same-edge re-issue keeps the bit set.
    if (iss_fire && (iss_rd != ZERO_REG)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    wen_d  = xfer && (xfer_rd != ZERO_REG);
    addr_d = wen_d ? xfer_rd : addr_q;
    data_d = wen_d ? xfer_data : data_q;
    err_d  = err_q | (wen_d & ~busy_q[xfer_rd]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign RegWEn  = wen_q;
  assign addr_rd = addr_q;
  assign data_rd = data_q;
  assign wb_err  = err_q;
  assign idle    = (busy_q == '0) & ~wen_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench with a behavioural scoreboard model checked every cycle.
module tb_regfile_wb_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic        iss_stall;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        RegWEn;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        idle, wb_err;

  always #5 clock = ~clock;

  regfile_wb_sched dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .RegWEn(RegWEn), .addr_rd(addr_rd), .data_rd(data_rd),
    .idle(idle), .wb_err(wb_err)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: which registers await a write, who won last, what is being written now.
  bit          m_busy[32];
  int          m_last;      // 0 = A won most recently, 1 = B
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;

  function automatic void exp_grant(output bit ga, output bit gb);
    if (a_valid && b_valid) begin
      ga = (m_last == 1);
      gb = !ga;
    end else begin
      ga = a_valid;
      gb = b_valid;
    end
  endfunction

  function automatic bit exp_stall();
    return iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
  endfunction

  function automatic bit exp_idle();
    for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b0;
    return !m_wen;
  endfunction

  always @(posedge clock or posedge reset) begin : model_upd
    bit ga, gb;
    logic [4:0]  rd;
    logic [31:0] d;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
      m_last <= 1;
      m_wen  <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_err  <= 1'b0;
    end else begin
      exp_grant(ga, gb);
      rd = gb ? b_rd : a_rd;
      d  = gb ? b_data : a_data;
      if (m_wen) m_busy[m_addr] <= 1'b0;
      if (iss_valid && !exp_stall() && iss_rd != 5'd0) m_busy[iss_rd] <= 1'b1;
      if ((ga || gb) && rd != 5'd0 && !m_busy[rd]) m_err <= 1'b1;
      m_wen <= (ga || gb) && (rd != 5'd0);
      if ((ga || gb) && rd != 5'd0) begin
        m_addr <= rd;
        m_data <= d;
      end
      if (ga) m_last <= 0;
      else if (gb) m_last <= 1;
    end
  end

  always @(negedge clock) begin : compare
    bit ga, gb;
    if (chk_on) begin
      exp_grant(ga, gb);
      chk("m_a_ready", a_ready, ga);
      chk("m_b_ready", b_ready, gb);
      chk("m_iss_stall", iss_stall, exp_stall());
      chk("m_RegWEn", RegWEn, m_wen);
      if (m_wen) begin
        chk("m_addr_rd", addr_rd, m_addr);
        chk("m_data_rd", data_rd, m_data);
      end
      chk("m_idle", idle, exp_idle());
      chk("m_wb_err", wb_err, m_err);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_wen", RegWEn, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_addr", addr_rd, 0);
    chk("rst_data", data_rd, 0);
    @(posedge clock);
    #2 reset = 1'b0;

    // Round-robin with both requesters valid, rd=1..4 all busy.
    for (int r = 1; r <= 4; r++) begin
      iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 5'(r);
      step();
    end
    iss_valid = 0;
    a_valid = 1; a_rd = 1; a_data = 32'h11;
    b_valid = 1; b_rd = 2; b_data = 32'h22;
    #1 chk("rr0_a", a_ready, 1); chk("rr0_b", b_ready, 0);
    step(); a_rd = 3; a_data = 32'h33;
    #1 chk("rr1_b", b_ready, 1); chk("rr1_wen", RegWEn, 1); chk("rr1_addr", addr_rd, 1);
    step(); b_rd = 4; b_data = 32'h44;
    #1 chk("rr2_a", a_ready, 1); chk("rr2_addr", addr_rd, 2); chk("rr2_data", data_rd, 32'h22);
    step();
    #1 chk("rr3_b", b_ready, 1); chk("rr3_a", a_ready, 0); chk("rr3_addr", addr_rd, 3);
    step(); a_valid = 0; b_valid = 0;
    #1 chk("rr4_addr", addr_rd, 4); chk("rr4_data", data_rd, 32'h44);
    step();
    #1 chk("rr_idle", idle, 1); chk("rr_wen", RegWEn, 0);

    // RAW interlock released one cycle after the write-back pulse.
    iss_valid = 1; iss_rs1 = 1; iss_rs2 = 2; iss_rd = 5;
    step();
    iss_rs1 = 5; iss_rs2 = 0; iss_rd = 6;
    #1 chk("raw_stall", iss_stall, 1); chk("raw_idle", idle, 0);
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    #1 chk("raw_a_ready", a_ready, 1);
    step(); a_valid = 0;
    #1 chk("raw_wen", RegWEn, 1); chk("raw_addr", addr_rd, 5);
    chk("raw_data", data_rd, 32'hDEADBEEF); chk("raw_still", iss_stall, 1);
    step();
    #1 chk("raw_release", iss_stall, 0);
    iss_valid = 0;

    // Write to r0 is accepted and dropped.
    a_valid = 1; a_rd = 0; a_data = 32'h55;
    #1 chk("r0_ready", a_ready, 1);
    step(); a_valid = 0;
    #1 chk("r0_wen", RegWEn, 0); chk("r0_err", wb_err, 0); chk("r0_idle", idle, 1);

    // Stray write sets the sticky error.
    b_valid = 1; b_rd = 7; b_data = 32'h77;
    #1 chk("err_ready", b_ready, 1);
    step(); b_valid = 0;
    #1 chk("err_set", wb_err, 1); chk("err_wen", RegWEn, 1); chk("err_addr", addr_rd, 7);

    // Issue rd=9 on the same edge a commit to 9 clears it: set wins.
    b_valid = 1; b_rd = 9; b_data = 32'h99;
    step(); b_valid = 0;
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 9;
    #1 chk("sw_nostall", iss_stall, 0); chk("sw_addr", addr_rd, 9); chk("sw_wen", RegWEn, 1);
    step();
    iss_rd = 0; iss_rs1 = 9;
    #1 chk("sw_busy9", iss_stall, 1); chk("sw_idle", idle, 0);
    iss_valid = 0;
    a_valid = 1; a_rd = 9; a_data = 32'h1234;
    step(); a_valid = 0;
    step();
    #1 chk("err_sticky", wb_err, 1); chk("sw_idle2", idle, 1);

    // Reset mid-transfer; last winner before reset is A.
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 12;
    step(); iss_valid = 0;
    a_valid = 1; a_rd = 12; a_data = 32'hC;
    #1 reset = 1'b1;
    #1 chk("mr_wen", RegWEn, 0); chk("mr_idle", idle, 1); chk("mr_err", wb_err, 0);
    step();
    step(); reset = 1'b0;
    a_valid = 1; a_rd = 0; b_valid = 1; b_rd = 0;
    #1 chk("mr_tie_a", a_ready, 1); chk("mr_tie_b", b_ready, 0);
    step();
    #1 chk("mr_next_b", b_ready, 1); chk("mr_wen2", RegWEn, 0);
    a_valid = 0; b_valid = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
